// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared constants for the MEM/WB stage
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_IMM = 2'b10,
        WB_SEL_PC  = 2'b11
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DEFAULT_PC_WIDTH = 32;

endpackage

// File: rtl/mem_wb_stage_wb_result_mux.sv
// rtl/mem_wb_stage_wb_result_mux.sv - write-back result select ahead of the capture register
module wb_result_mux
    import mem_wb_stage_pkg::*;
#(
    parameter int PC_WIDTH   = DEFAULT_PC_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            sel,
    input  logic [PC_WIDTH-1:0]   next_pc,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = alu_res;
        case (wb_sel_e'(sel))
            WB_SEL_ALU: result = alu_res;
            WB_SEL_MEM: result = mem_data;
            WB_SEL_IMM: result = imm;
            WB_SEL_PC:  result = DATA_WIDTH'(next_pc);
            default:    result = alu_res;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, register-file write port and forwarding sources
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int PC_WIDTH       = DEFAULT_PC_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_reg_write,
    input  logic [1:0]                in_wb_res_mux,
    input  logic [PC_WIDTH-1:0]       in_next_pc,
    input  logic [DATA_WIDTH-1:0]     in_mem_data,
    input  logic [DATA_WIDTH-1:0]     in_alu_res,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_reg_dst,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      fwd1_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd1_reg,
    output logic [DATA_WIDTH-1:0]     fwd1_data,
    output logic                      fwd2_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd2_reg,
    output logic [DATA_WIDTH-1:0]     fwd2_data,
    output logic [31:0]               retired_count
);

    logic [DATA_WIDTH-1:0]     wb_result;
    logic                      valid_q;
    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] reg_dst_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      fwd2_valid_q;
    logic [REG_ADDR_WIDTH-1:0] fwd2_reg_q;
    logic [DATA_WIDTH-1:0]     fwd2_data_q;
    logic [31:0]               count_q;

    wb_result_mux #(
        .PC_WIDTH  (PC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel     (in_wb_res_mux),
        .next_pc (in_next_pc),
        .mem_data(in_mem_data),
        .alu_res (in_alu_res),
        .imm     (in_imm),
        .result  (wb_result)
    );

    // Selecting before the register keeps the write-data path a plain flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= '0;
            data_q       <= '0;
            fwd2_valid_q <= 1'b0;
            fwd2_reg_q   <= '0;
            fwd2_data_q  <= '0;
            count_q      <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q     <= in_valid;
                reg_write_q <= in_reg_write;
                reg_dst_q   <= in_reg_dst;
                data_q      <= wb_result;
            end
            // A stalled write is repeated by the RF, so it is not a new post-WB source.
            fwd2_valid_q <= rf_write_en & ~stall;
            fwd2_reg_q   <= rf_write_addr;
            fwd2_data_q  <= rf_write_data;
            if (valid_q && !stall) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign rf_write_en   = valid_q & reg_write_q & (reg_dst_q != REG_ADDR_WIDTH'(REG_ZERO));
    assign rf_write_addr = reg_dst_q;
    assign rf_write_data = data_q;

    assign fwd1_valid = rf_write_en;
    assign fwd1_reg   = rf_write_addr;
    assign fwd1_data  = rf_write_data;

    assign fwd2_valid = fwd2_valid_q;
    assign fwd2_reg   = fwd2_reg_q;
    assign fwd2_data  = fwd2_data_q;

    assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [1:0]  in_wb_res_mux = 2'b00;
    logic [15:0] in_next_pc = '0;
    logic [31:0] in_mem_data = '0;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_reg_dst = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        fwd1_valid;
    logic [4:0]  fwd1_reg;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [4:0]  fwd2_reg;
    logic [31:0] fwd2_data;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(
        .PC_WIDTH      (16),
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_reg_write (in_reg_write),
        .in_wb_res_mux(in_wb_res_mux),
        .in_next_pc   (in_next_pc),
        .in_mem_data  (in_mem_data),
        .in_alu_res   (in_alu_res),
        .in_imm       (in_imm),
        .in_reg_dst   (in_reg_dst),
        .stall        (stall),
        .flush        (flush),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .fwd1_valid   (fwd1_valid),
        .fwd1_reg     (fwd1_reg),
        .fwd1_data    (fwd1_data),
        .fwd2_valid   (fwd2_valid),
        .fwd2_reg     (fwd2_reg),
        .fwd2_data    (fwd2_data),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sel,
                         input logic [4:0] dst, input logic [31:0] alu);
        in_valid      = v;
        in_reg_write  = w;
        in_wb_res_mux = sel;
        in_reg_dst    = dst;
        in_alu_res    = alu;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({rf_write_en, rf_write_addr, rf_write_data, fwd2_valid, fwd2_reg, fwd2_data, retired_count} !== '0) begin
            errors++;
            $display("FAIL reset_init: en=%0b addr=%0d data=%h fwd2=%0b count=%0d, want all zero",
                     rf_write_en, rf_write_addr, rf_write_data, fwd2_valid, retired_count);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 2'b00, 5'd4, 32'h55);
        tick();
        drive(1, 1, 2'b00, 5'd6, 32'h66);
        tick();
        checks++;
        if (!(rf_write_en === 1'b1 && retired_count === 32'd1)) begin
            errors++;
            $display("FAIL reset_prerun: en=%0b count=%0d, want 1 and 1", rf_write_en, retired_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rf_write_en, rf_write_addr, rf_write_data, fwd1_valid, fwd2_valid, fwd2_reg, fwd2_data, retired_count} !== '0) begin
            errors++;
            $display("FAIL reset_async: en=%0b addr=%0d data=%h fwd2=%0b count=%0d, want all zero",
                     rf_write_en, rf_write_addr, rf_write_data, fwd2_valid, retired_count);
        end
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mux_sweep();
        logic [31:0] exp_data [5];
        logic [15:0] pcs [5];
        exp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0000_F044};
        pcs      = '{16'h44, 16'h44, 16'h44, 16'h44, 16'hF044};
        in_mem_data = 32'h22;
        in_imm      = 32'h33;
        for (int i = 0; i < 5; i++) begin
            in_next_pc = pcs[i];
            drive(1, 1, (i == 4) ? 2'b11 : 2'(i), 5'd3, 32'h11);
            tick();
            checks++;
            if (!(rf_write_en === 1'b1 && rf_write_addr === 5'd3 && rf_write_data === exp_data[i])) begin
                errors++;
                $display("FAIL mux_sel%0d: en=%0b addr=%0d data=%h, want 1 3 %h",
                         i, rf_write_en, rf_write_addr, rf_write_data, exp_data[i]);
            end
        end
        checks++;
        if (retired_count !== 32'd4) begin
            errors++;
            $display("FAIL mux_count: count=%0d, want 4", retired_count);
        end
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        tick();
        checks++;
        if (!(rf_write_en === 1'b0 && retired_count === 32'd5)) begin
            errors++;
            $display("FAIL bubble: en=%0b count=%0d, want 0 5", rf_write_en, retired_count);
        end
    endtask

    task automatic test_r0();
        drive(1, 1, 2'b00, 5'd0, 32'h77);
        tick();
        checks++;
        if (!(rf_write_en === 1'b0 && fwd1_valid === 1'b0)) begin
            errors++;
            $display("FAIL r0_suppress: en=%0b fwd1=%0b, want 0 0", rf_write_en, fwd1_valid);
        end
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        tick();
        checks++;
        if (retired_count !== 32'd6) begin
            errors++;
            $display("FAIL r0_count: count=%0d, want 6", retired_count);
        end
    endtask

    task automatic test_stall();
        drive(1, 1, 2'b00, 5'd5, 32'hDEAD);
        tick();
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (!(rf_write_en === 1'b1 && rf_write_addr === 5'd5 && rf_write_data === 32'hDEAD &&
                  fwd2_valid === 1'b0 && retired_count === 32'd6)) begin
                errors++;
                $display("FAIL stall_cycle%0d: en=%0b addr=%0d data=%h fwd2=%0b count=%0d, want 1 5 dead 0 6",
                         i, rf_write_en, rf_write_addr, rf_write_data, fwd2_valid, retired_count);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (!(rf_write_en === 1'b0 && retired_count === 32'd7 && fwd2_valid === 1'b1 &&
              fwd2_reg === 5'd5 && fwd2_data === 32'hDEAD)) begin
            errors++;
            $display("FAIL stall_release: en=%0b count=%0d fwd2=%0b/%0d/%h, want 0 7 1/5/dead",
                     rf_write_en, retired_count, fwd2_valid, fwd2_reg, fwd2_data);
        end
    endtask

    task automatic test_flush_stall();
        drive(1, 1, 2'b00, 5'd9, 32'h99);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        checks++;
        if (!(rf_write_en === 1'b0 && retired_count === 32'd7)) begin
            errors++;
            $display("FAIL flush_stall: en=%0b count=%0d, want 0 7", rf_write_en, retired_count);
        end
        tick();
        checks++;
        if (retired_count !== 32'd7) begin
            errors++;
            $display("FAIL flush_nocount: count=%0d, want 7", retired_count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 2'b00, 5'd7, 32'hA);
        tick();
        drive(1, 1, 2'b00, 5'd8, 32'hB);
        tick();
        checks++;
        if (!(fwd1_valid === 1'b1 && fwd1_reg === 5'd8 && fwd1_data === 32'hB &&
              fwd2_valid === 1'b1 && fwd2_reg === 5'd7 && fwd2_data === 32'hA)) begin
            errors++;
            $display("FAIL fwd2_b2b: fwd1=%0b/%0d/%h fwd2=%0b/%0d/%h, want 1/8/b 1/7/a",
                     fwd1_valid, fwd1_reg, fwd1_data, fwd2_valid, fwd2_reg, fwd2_data);
        end
        checks++;
        if (retired_count !== 32'd8) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, want 8", retired_count);
        end
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        drive(0, 0, 2'b00, 5'd0, 32'h0);
        tick();
        checks++;
        if (retired_count !== 32'd0) begin
            errors++;
            $display("FAIL count_wrap: count=%h, want 00000000", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_mux_sweep();
        test_r0();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer side of the MEM stage outputs: MEM/WB pipeline register plus write-back result selection for core_lapido.
- Captures out_wb_res_mux / out_mem_data / out_alu_res / out_reg_dst / out_imm / out_next_pc and drives the register-file write port one cycle later.
- Also provides two-deep forwarding sources (WB and post-WB) to the hazard/forwarding logic, plus a retired-instruction counter.

Parameters:
- PC_WIDTH, `PC_WIDTH from lapido_defs.v, width of next_pc.
- DATA_WIDTH, 32, width of the data path.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  MEM stage holds a real instruction.
- in_reg_write  in  1  instruction writes a register.
- in_wb_res_mux  in  2  result select.
- in_next_pc  in  PC_WIDTH  link address.
- in_mem_data  in  DATA_WIDTH  data_mem read_data.
- in_alu_res  in  DATA_WIDTH  ALU result.
- in_imm  in  DATA_WIDTH  immediate.
- in_reg_dst  in  REG_ADDR_WIDTH  destination register.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  insert a bubble.
- rf_write_en  out  1  register-file write enable.
- rf_write_addr  out  REG_ADDR_WIDTH  write index.
- rf_write_data  out  DATA_WIDTH  write data.
- fwd1_valid / fwd1_reg / fwd1_data  out  1 / 5 / 32  WB-stage bypass (equals the rf write).
- fwd2_valid / fwd2_reg / fwd2_data  out  1 / 5 / 32  previous-cycle write (post-WB bypass).
- retired_count  out  32  count of retired valid instructions.

Behaviour:
- rst asserted at any time clears everything asynchronously:
  - valid_q=0, all data/address registers=0, fwd2 state=0, retired_count=0.
  - All outputs therefore read 0.
- Edge update priority: rst > flush > stall > load.
  - flush: valid_q<=0; other fields don't-care, held.
  - stall (no flush): all fields hold; fwd2 still updates per the fwd2 rule below.
  - load: valid_q<=in_valid; capture in_reg_write, in_wb_res_mux, in_reg_dst.
- Result select is performed at capture, so registered data is stored and there is no mux on the output path:
  - 00 = alu_res
  - 01 = mem_data
  - 10 = imm
  - 11 = next_pc, zero-extended to DATA_WIDTH if PC_WIDTH<32
- Latency: exactly 1 cycle from MEM-stage inputs to rf_write_*.
- rf_write_en = valid_q & reg_write_q & (reg_dst_q != 0). Writes to r0 are always suppressed.
- A stall holding a valid write keeps rf_write_en high every stalled cycle; the repeated write is idempotent and permitted.
- fwd1_* mirrors rf_write_* combinationally.
- fwd2 rule: on each non-reset edge, fwd2 state <= {rf_write_en & !stall, rf_write_addr, rf_write_data}.
  - This covers same-cycle read-before-write in the register file.
  - During a stall, fwd2_valid drops to 0 after one cycle.
- retired_count increments by 1 on each edge where valid_q=1 and stall=0, whether or not the instruction writes. It wraps at 2^32-1 -> 0.
- Simultaneous flush+stall: flush wins and the bubble is inserted.
- An in_valid=0 load acts as a bubble: no write, no count.

Decomposition:
- Add to lapido_defs.v:
  - `WB_SEL_ALU=2'b00, `WB_SEL_MEM=2'b01, `WB_SEL_IMM=2'b10, `WB_SEL_PC=2'b11
  - `REG_ZERO=5'd0
- One natural sub-module, wb_result_mux (combinational 4:1 select feeding the capture register). The forwarding history and counter stay in the top.

Test Plan:
1. Reset mid-run: rst pulsed asynchronously between edges while valid_q=1 -> all outputs 0 immediately, retired_count=0.
2. Mux sweep, one instruction per cycle with in_reg_write=1, in_reg_dst=3, alu=0x11, mem=0x22, imm=0x33, next_pc=0x44, selects 00/01/10/11 -> rf_write_data 0x11/0x22/0x33/0x44 on successive cycles, each one cycle after its input; retired_count reaches 4.
3. r0 suppression: in_reg_dst=0, in_reg_write=1, sel=00 -> rf_write_en=0, fwd1_valid=0, retired_count still increments.
4. Stall: load a write to r5=0xDEAD, then stall for 3 cycles -> rf_write_en stays 1 with the same addr/data; retired_count increments only on release; fwd2_valid=0 during the stall.
5. Flush+stall together on a valid input -> next cycle valid_q=0, rf_write_en=0, no count.
6. fwd2: consecutive writes r7=0xA then r8=0xB -> in the cycle r8 is on fwd1, fwd2 shows valid=1, reg=7, data=0xA. Also preload retired_count to 0xFFFFFFFF by forcing, retire one -> 0.
